store_buffer: RTL and testbench
===============================

# store_buffer

Store-path stage directly downstream of the store byte-enable decoder. Accepts one store per cycle (address, register data, low-aligned byte enables from the decoder), aligns data and enables to the word lane selected by `addr[1:0]`, traps misaligned accesses, and queues legal stores in a small FIFO. The FIFO drains to the data-memory write port over a valid/ready handshake, decoupling the pipeline from memory wait states.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `ADDR_W`, 32: byte-address width.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `st_valid`  in  1: store request present.
- `st_ready`  out  1: buffer can accept; equals `!full`.
- `st_addr`  in  ADDR_W: byte address.
- `st_wdata`  in  32: rs2 data, byte 0 in bits [7:0].
- `st_byte_enable`  in  4: decoder output: 0001 SB, 0011 SH, 1111 SW, 0000 invalid.
- `mem_valid`  out  1: head entry presented to memory.
- `mem_ready`  in  1: memory accepts the head entry this cycle.
- `mem_addr`  out  ADDR_W: word address, bits [1:0] always 0.
- `mem_wdata`  out  32: lane-aligned data.
- `mem_wstrb`  out  4: lane-aligned byte strobes.
- `misaligned`  out  1: one-cycle pulse, rejected store.
- `busy`  out  1: FIFO non-empty (used by fence/drain logic).

## Operation
- Accept: `st_valid && st_ready` in cycle N.
- Offset `off = st_addr[1:0]`. Aligned entry: addr = `st_addr & ~3`, wdata = `st_wdata << (8*off)`, wstrb = `st_byte_enable << off` (truncated to 4 bits).
- Misaligned if: be=0011 and off=3; be=1111 and off≠0; be=0000 (any off). Misaligned stores are handshaken (consumed) but NOT enqueued; `misaligned`=1 in cycle N+1 only.
- Legal stores enqueue at write pointer; count+1.
- Dequeue: `mem_valid && mem_ready`; head pointer advances, count−1.
- Head outputs held stable while `mem_valid && !mem_ready`.
- FIFO order strict; no merging, no reordering.
- Simultaneous enqueue+dequeue (not full): count unchanged, both pointers advance.
- Full: `st_ready`=0 even if memory accepts that same cycle (no same-cycle bypass of full).
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

## Timing
- Reset: count 0, pointers 0, all entries 0, `mem_valid` 0, `mem_addr`/`mem_wdata`/`mem_wstrb` 0, `misaligned` 0, `busy` 0, `st_ready` 1.
- Reset mid-operation discards every queued entry; no write issued in the reset cycle or after.
- Latency: store accepted at N → `mem_valid` at N+1 earliest (registered entry, no combinational path st_* → mem_*).
- Throughput: 1 store/cycle sustained while `mem_ready`=1.
- `st_ready`, `busy`, `mem_valid` derived from registered count only.
- `misaligned` registered, pulse width exactly 1 per rejected store; back-to-back rejects give consecutive-cycle pulses.

## Structure
- Shared package: byte-enable constants (BE_B=4'b0001, BE_H=4'b0011, BE_W=4'b1111, BE_NONE=4'b0000), entry struct {addr, wdata, wstrb}.
- Sub-module `store_align`: combinational offset shift and misalignment check; the FIFO and handshake stay in `store_buffer`.

## Test plan
- SB addr 0x1003, wdata 0x000000AB, `mem_ready`=1 → next cycle mem_addr 0x1000, wdata 0xAB000000, wstrb 1000, one beat.
- SH addr 0x2002, wdata 0x1234 → wdata 0x12340000, wstrb 1100; SH addr 0x2003 → no mem beat, `misaligned` pulse 1 cycle.
- SW addr 0x3001 and be=0000 at 0x3000 → both rejected, two pulses, `busy` stays 0.
- `mem_ready`=0, three SW stores 0x10,0x14,0x18 → first two queued, `st_ready`=0 on third; release `mem_ready` → writes 0x10,0x14 then 0x18 in order, head held stable while stalled.
- Full FIFO with `mem_ready`=1 and `st_valid`=1 → no accept that cycle; next cycle accept, count stays constant thereafter at 1 store/cycle.
- Assert `rst` with 2 entries queued and `mem_ready`=0 → next cycle `mem_valid`=0, `busy`=0, `st_ready`=1, no stale write after reset release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module : store_buffer_pkg
// Brief  : Byte-enable encodings and lane payload type shared by the store path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package store_buffer_pkg;

    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sb_lane_t;

endpackage

`default_nettype wire

// File: rtl/store_align.sv
// ============================================================================
// Module : store_align
// Brief  : Shifts store data/enables onto the word lane and flags misalignment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import store_buffer_pkg::*;

module store_align (
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output sb_lane_t    o_lane,
    output logic        o_misaligned
);

    always_comb begin
        o_lane.wdata = i_wdata << {i_off, 3'b000};
        // Four-bit shift drops enables that would cross into the next word.
        o_lane.wstrb = i_be << i_off;
        o_misaligned = 1'b0;
        case (i_be)
            BE_NONE: o_misaligned = 1'b1;
            BE_H:    o_misaligned = (i_off == 2'd3);
            BE_W:    o_misaligned = (i_off != 2'd0);
            default: o_misaligned = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module : store_buffer
// Brief  : Aligns incoming stores, rejects misaligned ones, and queues legal
//          stores in a FIFO drained to the data-memory write port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import store_buffer_pkg::*;

module store_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [3:0]        st_byte_enable,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              misaligned,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Only the word address is stored; the low two bits are implied zero.
    typedef struct packed {
        logic [ADDR_W-3:0] word;
        sb_lane_t          lane;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_misaligned;

    sb_lane_t           w_lane;
    logic               w_bad;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    store_align u_align (
        .i_off        (st_addr[1:0]),
        .i_wdata      (st_wdata),
        .i_be         (st_byte_enable),
        .o_lane       (w_lane),
        .o_misaligned (w_bad)
    );

    assign st_ready   = (r_count != CNT_W'(DEPTH));
    assign mem_valid  = (r_count != '0);
    assign busy       = mem_valid;
    assign misaligned = r_misaligned;

    assign w_accept = st_valid && st_ready;
    assign w_push   = w_accept && !w_bad;
    assign w_pop    = mem_valid && mem_ready;

    // Head is masked when empty so the port idles at zero after draining.
    assign w_head    = r_mem[r_rd_ptr];
    assign mem_addr  = mem_valid ? {w_head.word, 2'b00} : '0;
    assign mem_wdata = mem_valid ? w_head.lane.wdata    : '0;
    assign mem_wstrb = mem_valid ? w_head.lane.wstrb    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_bad;
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{word: st_addr[ADDR_W-1:2], lane: w_lane};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module : tb_store_buffer
// Brief  : Scoreboard bench for store_buffer with directed and random stores.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_byte_enable;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        misaligned;
    logic        busy;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_wdata       (st_wdata),
        .st_byte_enable (st_byte_enable),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .misaligned     (misaligned),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt = 0;
    bit   m_mis = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: occupancy counter plus a queue of expected writes.
    initial begin : model
        int   off;
        bit   legal;
        bit   pop_now;
        bit   room;
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                m_cnt = 0;
                m_mis = 1'b0;
            end else begin
                off = int'(st_addr[1:0]);
                case (st_byte_enable)
                    4'b0001: legal = 1'b1;
                    4'b0011: legal = (off != 3);
                    4'b1111: legal = (off == 0);
                    4'b0000: legal = 1'b0;
                    default: legal = 1'b1;
                endcase
                room    = (m_cnt < DEPTH);
                pop_now = (m_cnt > 0) && mem_ready;
                m_mis   = st_valid && room && !legal;
                if (st_valid && room && legal) begin
                    e.addr  = st_addr - 32'(off);
                    e.wdata = st_wdata << (8 * off);
                    e.wstrb = 4'(8'(st_byte_enable) << off);
                    exp_q.push_back(e);
                    m_cnt++;
                end
                if (pop_now) m_cnt--;
            end
        end
    end

    // Monitor: compares status every cycle and pops on each memory beat.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!done) begin
                chk("st_ready",   64'(st_ready),   64'(m_cnt < DEPTH));
                chk("busy",       64'(busy),       64'(m_cnt != 0));
                chk("mem_valid",  64'(mem_valid),  64'(m_cnt != 0));
                chk("misaligned", 64'(misaligned), 64'(m_mis));
                if (mem_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        chk("mem_addr",  64'(mem_addr),  64'(exp_q[0].addr));
                        chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
                        chk("mem_wstrb", 64'(mem_wstrb), 64'(exp_q[0].wstrb));
                        if (mem_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit mr);
        st_valid       = v;
        st_addr        = a;
        st_wdata       = d;
        st_byte_enable = be;
        mem_ready      = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit mr, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 4'h0, mr);
    endtask

    initial begin : stim
        logic [3:0] be;
        rst = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_byte_enable = '0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_st_ready",  64'(st_ready),  64'(1));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_mem_addr",  64'(mem_addr),  64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // SB to byte 3
        drive(1'b1, 32'h1003, 32'h000000AB, 4'b0001, 1'b1);
        st_valid = 1'b0;
        @(negedge clk);
        chk("sb_addr",  64'(mem_addr),  64'h1000);
        chk("sb_wdata", 64'(mem_wdata), 64'hAB000000);
        chk("sb_wstrb", 64'(mem_wstrb), 64'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sb_one_beat", 64'(mem_valid), 64'(0));

        // SH upper half, then misaligned SH
        drive(1'b1, 32'h2002, 32'h00001234, 4'b0011, 1'b1);
        drive(1'b1, 32'h2003, 32'h00005678, 4'b0011, 1'b1);
        st_valid = 1'b0;
        @(negedge clk);
        chk("sh_mis_pulse", 64'(misaligned), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("sh_mis_end", 64'(misaligned), 64'(0));
        chk("sh_no_beat", 64'(mem_valid),  64'(0));

        // Back-to-back rejects
        drive(1'b1, 32'h3001, 32'hDEADBEEF, 4'b1111, 1'b1);
        st_addr = 32'h3000; st_byte_enable = 4'b0000;
        @(negedge clk);
        chk("rej1_pulse", 64'(misaligned), 64'(1));
        chk("rej1_busy",  64'(busy),       64'(0));
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("rej2_pulse", 64'(misaligned), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rej_end", 64'(misaligned), 64'(0));

        // Stall with full FIFO, then release
        drive(1'b1, 32'h10, 32'h11111111, 4'b1111, 1'b0);
        drive(1'b1, 32'h14, 32'h22222222, 4'b1111, 1'b0);
        st_addr = 32'h18; st_wdata = 32'h33333333;
        @(negedge clk);
        chk("full_not_ready", 64'(st_ready), 64'(0));
        chk("stall_head",     64'(mem_addr), 64'h10);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("full_no_bypass", 64'(st_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_ready", 64'(st_ready), 64'(1));
        chk("second_head",     64'(mem_addr), 64'h14);
        @(posedge clk); #1;
        // Sustained full-rate streaming
        for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'b1111, 1'b1);
        idle(1'b1, 3);

        // Reset with two entries queued
        drive(1'b1, 32'h40, 32'hA5A5A5A5, 4'b1111, 1'b0);
        drive(1'b1, 32'h44, 32'h5A5A5A5A, 4'b1111, 1'b0);
        st_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 64'(mem_valid), 64'(0));
        chk("rst_mid_busy",  64'(busy),      64'(0));
        chk("rst_mid_ready", 64'(st_ready),  64'(1));
        idle(1'b1, 4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0:       be = 4'b0001;
                1:       be = 4'b0011;
                2:       be = 4'b1111;
                default: be = ($urandom_range(3) == 0) ? 4'b0000 : 4'b1111;
            endcase
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
                rst = 1'b0;
            end else begin
                drive(($urandom_range(3) != 0), $urandom, $urandom, be,
                      ($urandom_range(9) < 6));
            end
        end
        idle(1'b1, 6);
        chk("drained", 64'(exp_q.size()), 64'(0));
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
